id_ex_stage: RTL

- Decode-to-execute pipeline stage that sits directly upstream of the 32-bit ALU.
- Selects the ALU operands: register value, forwarded result, zero-extended shift amount, or extended immediate.
- Detects load-use and RAW hazards, then registers operands, aluc and control for the EX cycle.
- Drives a stall back to fetch/decode and absorbs branch flushes by inserting bubbles.

---
 rtl/id_ex_stage.sv | 102 ++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register: operand select with EX/MEM forwarding,
// load-use/RAW hazard detection, stall generation and flush bubbles.
module id_ex_stage #(
  parameter bit         FWD_EN  = 1'b1,
  parameter logic [4:0] RF_ZERO = 5'd0
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        d_valid,
  input  logic [31:0] d_ra,
  input  logic [31:0] d_rb,
  input  logic [4:0]  d_rs,
  input  logic [4:0]  d_rt,
  input  logic        d_use_rs,
  input  logic        d_use_rt,
  input  logic [15:0] d_imm,
  input  logic [4:0]  d_sa,
  input  logic        d_shift,
  input  logic        d_aluimm,
  input  logic        d_sext,
  input  logic [3:0]  d_aluc,
  input  logic        d_wreg,
  input  logic        d_m2reg,
  input  logic [4:0]  d_rn,
  input  logic [31:0] ex_s,
  input  logic        m_wreg,
  input  logic [4:0]  m_rn,
  input  logic [31:0] m_res,
  input  logic        flush,
  output logic        stall,
  output logic        e_valid,
  output logic [31:0] e_a,
  output logic [31:0] e_b,
  output logic [3:0]  e_aluc,
  output logic        e_wreg,
  output logic        e_m2reg,
  output logic [4:0]  e_rn
);

  logic        hite_rs, hite_rt, hitm_rs, hitm_rt;
  logic        haz_rs, haz_rt, bubble;
  logic [31:0] fwd_a, fwd_b, imm_ext, op_a, op_b;

  // The zero register is excluded from every match, so it never stalls or forwards.
  assign hite_rs = e_valid & e_wreg & (e_rn == d_rs) & (d_rs != RF_ZERO);
  assign hite_rt = e_valid & e_wreg & (e_rn == d_rt) & (d_rt != RF_ZERO);
  assign hitm_rs = m_wreg & (m_rn == d_rs) & (d_rs != RF_ZERO);
  assign hitm_rt = m_wreg & (m_rn == d_rt) & (d_rt != RF_ZERO);

  // Without forwarding every in-flight producer is a hazard; with it, only a load in EX.
  assign haz_rs = d_use_rs & (FWD_EN ? (hite_rs & e_m2reg) : (hite_rs | hitm_rs));
  assign haz_rt = d_use_rt & (FWD_EN ? (hite_rt & e_m2reg) : (hite_rt | hitm_rt));

  assign stall  = (haz_rs | haz_rt) & d_valid & ~flush;
  assign bubble = flush | stall | ~d_valid;

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    fwd_a = d_ra;
    fwd_b = d_rb;
    if (FWD_EN) begin
      if (hite_rs && !e_m2reg) fwd_a = ex_s;
      else if (hitm_rs)        fwd_a = m_res;
      if (hite_rt && !e_m2reg) fwd_b = ex_s;
      else if (hitm_rt)        fwd_b = m_res;
    end
  end

  assign imm_ext = d_sext ? {{16{d_imm[15]}}, d_imm} : {16'b0, d_imm};
  assign op_a    = d_shift  ? {27'b0, d_sa} : fwd_a;
  assign op_b    = d_aluimm ? imm_ext       : fwd_b;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      e_valid <= 1'b0;
      e_a     <= '0;
      e_b     <= '0;
      e_aluc  <= '0;
      e_wreg  <= 1'b0;
      e_m2reg <= 1'b0;
      e_rn    <= '0;
    end else if (bubble) begin
      e_valid <= 1'b0;
      e_a     <= '0;
      e_b     <= '0;
      e_aluc  <= '0;
      e_wreg  <= 1'b0;
      e_m2reg <= 1'b0;
      e_rn    <= '0;
    end else begin
      e_valid <= 1'b1;
      e_a     <= op_a;
      e_b     <= op_b;
      e_aluc  <= d_aluc;
      e_wreg  <= d_wreg;
      e_m2reg <= d_m2reg;
      e_rn    <= d_rn;
    end
  end

endmodule
